sid_bus_master: RTL and testbench
=================================

SID_BUS_MASTER -- requirements
Module: sid_bus_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, command FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  in  1  master clock; all logic clocked on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port clkEn  in  1  1 MHz enable shared with the SID.
REQ-005 SHALL have port iCmdValid  in  1  command offered.
REQ-006 SHALL have port oCmdReady  out  1  command accepted when iCmdValid & oCmdReady on a clk edge.
REQ-007 SHALL have port iCmdWrite  in  1  1 = register write, 0 = register read.
REQ-008 SHALL have port iCmdAddr  in  5  SID register address.
REQ-009 SHALL have port iCmdData  in  8  write data (ignored for reads).
REQ-010 SHALL have port iCmdDelay  in  16  clkEn ticks to wait before issuing.
REQ-011 SHALL have port oRspValid  out  1  read data available.
REQ-012 SHALL have port iRspReady  in  1  read data consumed when oRspValid & iRspReady.
REQ-013 SHALL have port oRspData  out  8  read data.
REQ-014 SHALL have ports oWE out 1, oAddr out 5, oDataW out 8, iDataR in 8: SID bus (iWE/iAddr/iDataW/oDataR of the SID).
REQ-015 SHALL have port oBusy  out  1  high while FIFO non-empty or FSM not IDLE.

Function
REQ-016 SHALL buffer commands in a FIFO of FIFO_DEPTH entries {write, addr, data, delay}; oCmdReady = !full, independent of pop in the same cycle.
REQ-017 SHALL ignore iCmdValid while full (no overwrite, no count change).
REQ-018 SHALL implement FSM states IDLE, WAIT, ISSUE, RSP.
REQ-019 IDLE: if FIFO non-empty, pop head into holding register, load delay counter with delay, go WAIT; else stay.
REQ-020 WAIT: on each clkEn cycle, if counter==0 go ISSUE, else decrement; delay N means the command issues on the (N+1)th clkEn cycle seen in WAIT.
REQ-021 ISSUE (one clk cycle): drive oAddr=addr; write: oWE=1, oDataW=data, next IDLE; read: oWE=0, capture iDataR into oRspData at end of cycle, next RSP.
REQ-022 oWE SHALL be high for exactly one clk cycle per write command and never otherwise.
REQ-023 RSP: oRspValid=1, oRspData stable; on iRspReady go IDLE; FIFO not popped while in RSP.
REQ-024 oAddr and oDataW SHALL hold the last issued values between commands.
REQ-025 Commands SHALL issue strictly in acceptance order; a read blocks subsequent commands until its response is consumed.
REQ-026 Push into empty FIFO at edge t SHALL be popped no earlier than edge t+1 (no fall-through).
REQ-027 Counter SHALL not wrap: delay 0xFFFF waits exactly 65536 clkEn cycles before issuing.
REQ-028 clkEn high permanently SHALL give back-to-back delay-0 writes one per 3 clk cycles (IDLE, WAIT, ISSUE).

Reset
REQ-029 rst SHALL immediately force: FSM IDLE, FIFO empty, oWE=0, oAddr=0, oDataW=0, oRspValid=0, oRspData=0, counter=0, oBusy=0; oCmdReady=1.
REQ-030 rst asserted mid-WAIT, mid-ISSUE or in RSP SHALL discard the in-flight and queued commands; no oWE pulse after rst rises.

Structure
REQ-031 Shared package sid_pkg SHALL hold register address constants (0x17 FILT, 0x18 MODE/VOL, 0x19 POTX, 0x1A POTY, 0x1B OSC3, 0x1C ENV3), the FSM state enum and the command record type.
REQ-032 The FIFO SHALL be a sub-module sid_cmd_fifo (push/pop/full/empty, async active-high reset); FSM and bus drive in sid_bus_master.

Verification
REQ-033 Write 0x18<-0x0F, delay 0, clkEn every 16 clk -> single oWE pulse, oAddr=0x18, oDataW=0x0F, coincident with first clkEn in WAIT.
REQ-034 Read 0x1B with SID model returning 0xA5, iRspReady low 10 cycles -> oRspValid held 10+ cycles, oRspData=0xA5, next queued command waits.
REQ-035 Push 9 commands back-to-back with FIFO_DEPTH=8 and clkEn low -> 8 accepted, oCmdReady low on 9th, 9th retried after first pop.
REQ-036 Write with delay 3 -> oWE on 4th clkEn cycle after entering WAIT; delay 0xFFFF -> 65536 clkEn cycles.
REQ-037 Assert rst during WAIT with 4 queued commands -> no oWE ever, oBusy=0, oCmdReady=1 while rst high.
REQ-038 clkEn tied high, 4 delay-0 writes -> oWE pulses at 3-cycle spacing, addresses in push order.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared SID bus definitions: register map, master FSM states and the queued command record.
package sid_pkg;

    localparam logic [4:0] SidAddrFilt = 5'h17;
    localparam logic [4:0] SidAddrMode = 5'h18;
    localparam logic [4:0] SidAddrPotX = 5'h19;
    localparam logic [4:0] SidAddrPotY = 5'h1A;
    localparam logic [4:0] SidAddrOsc3 = 5'h1B;
    localparam logic [4:0] SidAddrEnv3 = 5'h1C;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StIssue,
        StRsp
    } state_e;

    typedef struct packed {
        logic        write;
        logic [4:0]  addr;
        logic [7:0]  data;
        logic [15:0] delay;
    } cmd_t;

    localparam int unsigned CmdBits = $bits(cmd_t);

endpackage

// File: rtl/sid_cmd_fifo.sv
// Registered command FIFO: head is valid only from the edge after a push, so no fall-through.
module sid_cmd_fifo
    import sid_pkg::*;
#(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = CmdBits
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == Depth[PtrW:0]);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sid_bus_master.sv
// Queues SID register reads/writes and issues them on the SID bus after a clkEn-tick delay.
module sid_bus_master
    import sid_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clkEn,
    input  logic        iCmdValid,
    output logic        oCmdReady,
    input  logic        iCmdWrite,
    input  logic [4:0]  iCmdAddr,
    input  logic [7:0]  iCmdData,
    input  logic [15:0] iCmdDelay,
    output logic        oRspValid,
    input  logic        iRspReady,
    output logic [7:0]  oRspData,
    output logic        oWE,
    output logic [4:0]  oAddr,
    output logic [7:0]  oDataW,
    input  logic [7:0]  iDataR,
    output logic        oBusy
);

    state_e      state_q;
    cmd_t        hold_q;
    cmd_t        push_cmd;
    cmd_t        head_cmd;
    logic [15:0] cnt_q;
    logic        we_q;
    logic [4:0]  addr_q;
    logic [7:0]  dataw_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_data_q;
    logic        fifo_full, fifo_empty, fifo_pop;

    assign push_cmd = '{write: iCmdWrite, addr: iCmdAddr, data: iCmdData, delay: iCmdDelay};
    assign fifo_pop = (state_q == StIdle) && !fifo_empty;

    sid_cmd_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (CmdBits)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (iCmdValid),
        .data_i  (push_cmd),
        .pop_i   (fifo_pop),
        .data_o  (head_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            dataw_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        hold_q  <= head_cmd;
                        cnt_q   <= head_cmd.delay;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    // Counting down to zero, then one more tick, gives delay+1 ticks without wrap.
                    if (clkEn) begin
                        if (cnt_q == '0) begin
                            state_q <= StIssue;
                            addr_q  <= hold_q.addr;
                            if (hold_q.write) begin
                                we_q    <= 1'b1;
                                dataw_q <= hold_q.data;
                            end
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                end
                StIssue: begin
                    if (hold_q.write) begin
                        state_q <= StIdle;
                    end else begin
                        rsp_data_q  <= iDataR;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StRsp;
                    end
                end
                StRsp: begin
                    if (iRspReady) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign oCmdReady = !fifo_full;
    assign oWE       = we_q;
    assign oAddr     = addr_q;
    assign oDataW    = dataw_q;
    assign oRspValid = rsp_valid_q;
    assign oRspData  = rsp_data_q;
    assign oBusy     = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_sid_bus_master.sv
// Directed bench for sid_bus_master with a combinational SID read model.
module tb_sid_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clkEn = 1'b0;
    logic        iCmdValid = 1'b0;
    logic        oCmdReady;
    logic        iCmdWrite = 1'b0;
    logic [4:0]  iCmdAddr = '0;
    logic [7:0]  iCmdData = '0;
    logic [15:0] iCmdDelay = '0;
    logic        oRspValid;
    logic        iRspReady = 1'b0;
    logic [7:0]  oRspData;
    logic        oWE;
    logic [4:0]  oAddr;
    logic [7:0]  oDataW;
    logic [7:0]  iDataR;
    logic        oBusy;

    int tests = 0;
    int fails = 0;
    int en_mode = 0;
    logic [3:0] div = '0;
    int en_count = 0;
    int cyc = 0;
    int nw = 0;
    logic [4:0] wr_addr [64];
    logic [7:0] wr_data [64];
    int         wr_cyc  [64];

    sid_bus_master #(.FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clkEn     (clkEn),
        .iCmdValid (iCmdValid),
        .oCmdReady (oCmdReady),
        .iCmdWrite (iCmdWrite),
        .iCmdAddr  (iCmdAddr),
        .iCmdData  (iCmdData),
        .iCmdDelay (iCmdDelay),
        .oRspValid (oRspValid),
        .iRspReady (iRspReady),
        .oRspData  (oRspData),
        .oWE       (oWE),
        .oAddr     (oAddr),
        .oDataW    (oDataW),
        .iDataR    (iDataR),
        .oBusy     (oBusy)
    );

    always #5 clk = ~clk;

    // SID model: OSC3 reads 0xA5, other registers return addr ^ 0x3C.
    assign iDataR = (oAddr == 5'h1B) ? 8'hA5 : ({3'b000, oAddr} ^ 8'h3C);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (oWE === 1'b1) begin
            if (nw < 64) begin
                wr_addr[nw] <= oAddr;
                wr_data[nw] <= oDataW;
                wr_cyc[nw]  <= cyc;
            end
            nw <= nw + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        case (en_mode)
            0:       clkEn = 1'b0;
            1:       clkEn = 1'b1;
            default: clkEn = (div == 4'd15);
        endcase
        div = div + 4'd1;
        @(posedge clk);
        #1;
        if (clkEn) en_count++;
    endtask

    task automatic push(input logic w, input logic [4:0] a, input logic [7:0] d,
                        input logic [15:0] dl);
        int n = 0;
        iCmdValid = 1'b1;
        iCmdWrite = w;
        iCmdAddr  = a;
        iCmdData  = d;
        iCmdDelay = dl;
        while (!oCmdReady && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("push_ready_timeout", 32'(oCmdReady), 32'd1);
        step();
        iCmdValid = 1'b0;
    endtask

    task automatic wait_we(input int bound, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            if (oWE) seen = 1'b1;
        end
    endtask

    task automatic wait_rsp(input int bound, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            if (oRspValid) seen = 1'b1;
        end
    endtask

    initial begin
        logic seen;
        int base;
        int snap;
        int bad;

        // Reset state
        step();
        step();
        check("rst_we", 32'(oWE), 32'd0);
        check("rst_addr", 32'(oAddr), 32'd0);
        check("rst_dataw", 32'(oDataW), 32'd0);
        check("rst_rspvalid", 32'(oRspValid), 32'd0);
        check("rst_rspdata", 32'(oRspData), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_ready", 32'(oCmdReady), 32'd1);
        rst = 1'b0;
        step();

        // Delay-0 write with sparse clkEn: issues on the first tick seen in WAIT
        en_mode = 2;
        push(1'b1, 5'h18, 8'h0F, 16'd0);
        step();
        base = en_count;
        wait_we(100, seen);
        check("w0_seen", 32'(seen), 32'd1);
        check("w0_ticks", 32'(en_count - base), 32'd1);
        check("w0_on_tick", 32'(clkEn), 32'd1);
        check("w0_addr", 32'(oAddr), 32'h18);
        check("w0_data", 32'(oDataW), 32'h0F);
        for (int i = 0; i < 40; i++) step();
        check("w0_single", 32'(nw), 32'd1);
        check("w0_idle", 32'(oBusy), 32'd0);

        // Read stalls the following write until the response is consumed
        en_mode = 1;
        push(1'b0, 5'h1B, 8'h00, 16'd0);
        push(1'b1, 5'h17, 8'h55, 16'd0);
        wait_rsp(50, seen);
        check("rd_seen", 32'(seen), 32'd1);
        check("rd_data", 32'(oRspData), 32'hA5);
        snap = nw;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (oRspValid !== 1'b1 || oRspData !== 8'hA5) bad++;
        end
        check("rd_hold", 32'(bad), 32'd0);
        check("rd_blocks", 32'(nw - snap), 32'd0);
        check("rd_addr_hold", 32'(oAddr), 32'h1B);
        check("rd_dataw_hold", 32'(oDataW), 32'h0F);
        iRspReady = 1'b1;
        step();
        iRspReady = 1'b0;
        check("rd_consumed", 32'(oRspValid), 32'd0);
        wait_we(20, seen);
        check("w1_seen", 32'(seen), 32'd1);
        check("w1_addr", 32'(oAddr), 32'h17);
        check("w1_data", 32'(oDataW), 32'h55);

        // Fill the FIFO while a read response is pending
        push(1'b0, 5'h19, 8'h00, 16'd0);
        wait_rsp(50, seen);
        check("rd2_data", 32'(oRspData), 32'h25);
        en_mode = 0;
        bad = 0;
        iCmdValid = 1'b1;
        iCmdWrite = 1'b1;
        iCmdDelay = 16'd0;
        for (int i = 0; i < 8; i++) begin
            iCmdAddr = 5'(i);
            iCmdData = 8'(8'h10 + i);
            if (oCmdReady !== 1'b1) bad++;
            step();
        end
        check("fill_ready", 32'(bad), 32'd0);
        check("full_not_ready", 32'(oCmdReady), 32'd0);
        iCmdAddr = 5'd8;
        iCmdData = 8'h18;
        step();
        step();
        step();
        check("full_stays", 32'(oCmdReady), 32'd0);
        check("full_busy", 32'(oBusy), 32'd1);
        iRspReady = 1'b1;
        step();
        iRspReady = 1'b0;
        check("full_after_rsp", 32'(oCmdReady), 32'd0);
        step();
        check("ready_after_pop", 32'(oCmdReady), 32'd1);
        step();
        check("ninth_taken", 32'(oCmdReady), 32'd0);
        iCmdValid = 1'b0;
        base = nw;
        en_mode = 1;
        for (int i = 0; i < 100 && nw < base + 9; i++) step();
        step();
        check("burst_count", 32'(nw - base), 32'd9);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("burst_addr%0d", k), 32'(wr_addr[base + k]), 32'(k));
            check($sformatf("burst_data%0d", k), 32'(wr_data[base + k]), 32'(8'h10 + k));
            if (k > 0)
                check($sformatf("burst_gap%0d", k), 32'(wr_cyc[base + k] - wr_cyc[base + k - 1]),
                      32'd3);
        end
        for (int i = 0; i < 10; i++) step();
        check("hold_addr", 32'(oAddr), 32'h08);
        check("hold_dataw", 32'(oDataW), 32'h18);

        // Delay 3 with sparse clkEn, then delay 0xFFFF with clkEn high
        en_mode = 2;
        push(1'b1, 5'h1A, 8'h77, 16'd3);
        step();
        base = en_count;
        wait_we(200, seen);
        check("d3_seen", 32'(seen), 32'd1);
        check("d3_ticks", 32'(en_count - base), 32'd4);
        check("d3_addr", 32'(oAddr), 32'h1A);
        en_mode = 1;
        push(1'b1, 5'h1C, 8'h99, 16'hFFFF);
        step();
        base = en_count;
        wait_we(70000, seen);
        check("dmax_seen", 32'(seen), 32'd1);
        check("dmax_ticks", 32'(en_count - base), 32'd65536);
        check("dmax_data", 32'(oDataW), 32'h99);

        // Reset during WAIT with four commands queued
        en_mode = 0;
        for (int i = 0; i < 5; i++) push(1'b1, 5'(5'h10 + i), 8'hE0, 16'd0);
        step();
        snap = nw;
        rst = 1'b1;
        #1;
        check("rstw_busy", 32'(oBusy), 32'd0);
        check("rstw_ready", 32'(oCmdReady), 32'd1);
        check("rstw_addr", 32'(oAddr), 32'd0);
        en_mode = 1;
        step();
        step();
        step();
        check("rstw_busy_held", 32'(oBusy), 32'd0);
        check("rstw_ready_held", 32'(oCmdReady), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) step();
        check("rstw_no_we", 32'(nw - snap), 32'd0);
        check("rstw_idle", 32'(oBusy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
